rst_sequencer: RTL and testbench

//   Staged reset controller for the fish tank subsystems (sensors, pump/motor, display, ...).

---
 rtl/rst_sequencer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_rst_sequencer.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/rst_sequencer.sv
// -----------------------------------------------------------------------------
// rst_sequencer
//   Staged reset controller for the fish tank subsystems. The controller holds
//   every subsystem in reset. It then releases the subsystems one at a time, in
//   index order starting at 0. A stage is released only after the previous
//   stage reports ready and a minimum spacing has elapsed. If a released stage
//   never reports ready, the controller reports a timeout fault. It also
//   reports a fault if any stage drops ready after the sequence completes. A
//   software request restarts the whole sequence from any state.
//
// Ports
//   clk          in   1         system clock
//   rst_n        in   1         asynchronous active-low reset
//   sw_rst_req   in   1         one-cycle pulse: abort and restart the sequence
//   stage_ready  in   N_STAGES  per-stage ready level from released subsystems
//   stage_rst_n  out  N_STAGES  per-stage active-low reset (registered)
//   seq_busy     out  1         high in HOLD / WAIT
//   seq_done     out  1         high in DONE
//   fault        out  1         high in FAULT
//   fault_stage  out  4         stage index that timed out or dropped ready
// -----------------------------------------------------------------------------
module rst_sequencer #(
    parameter int N_STAGES  = 4,
    parameter int CNT_W     = 32,
    parameter int HOLD_CYC  = 1000,
    parameter int STAGE_DLY = 50000,
    parameter int TIMEOUT   = 5000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sw_rst_req,
    input  logic [N_STAGES-1:0] stage_ready,
    output logic [N_STAGES-1:0] stage_rst_n,
    output logic                seq_busy,
    output logic                seq_done,
    output logic                fault,
    output logic [3:0]          fault_stage
);

    localparam int K_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

    localparam logic [CNT_W-1:0]    HOLD_LAST = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0]    DLY_LAST  = CNT_W'(STAGE_DLY - 1);
    localparam logic [CNT_W-1:0]    TO_LAST   = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]    CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
    localparam logic [K_W-1:0]      K_LAST    = K_W'(N_STAGES - 1);
    localparam logic [K_W-1:0]      K_ONE     = K_W'(1);
    localparam logic [N_STAGES-1:0] ALL_ONES  = {N_STAGES{1'b1}};

    typedef enum logic [1:0] {
        ST_HOLD  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [K_W-1:0]      k_q, k_d;
    logic [3:0]          fstage_q, fstage_d;
    logic [N_STAGES-1:0] stage_rst_n_q, stage_rst_n_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                fault_q, fault_d;

    // Thermometer mask: bits 0..k set (released stages while sequencing).
    function automatic logic [N_STAGES-1:0] therm(input logic [K_W-1:0] k);
        logic [N_STAGES-1:0] m;
        m = {N_STAGES{1'b0}};
        for (int i = 0; i < N_STAGES; i++) begin
            if (i <= int'(k)) begin
                m[i] = 1'b1;
            end else begin
                m[i] = 1'b0;
            end
        end
        return m;
    endfunction

    // Index of the lowest stage whose ready bit is low (0 when none is low).
    function automatic logic [3:0] lowest_low(input logic [N_STAGES-1:0] r);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = N_STAGES - 1; i >= 0; i--) begin
            if (!r[i]) begin
                idx = 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Next-state logic: sequencing, timeout and fault detection.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        k_d      = k_q;
        fstage_d = fstage_q;
        if (sw_rst_req) begin
            // Software restart wins over any same-cycle ready or timeout event.
            state_d  = ST_HOLD;
            cnt_d    = {CNT_W{1'b0}};
            k_d      = {K_W{1'b0}};
            fstage_d = 4'd0;
        end else begin
            case (state_q)
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        state_d = ST_WAIT;
                        cnt_d   = {CNT_W{1'b0}};
                        k_d     = {K_W{1'b0}};
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                ST_WAIT: begin
                    // Ready is sampled as a level. A ready that is seen before
                    // the spacing has elapsed is not remembered.
                    if (stage_ready[k_q] && (cnt_q >= DLY_LAST)) begin
                        cnt_d = {CNT_W{1'b0}};
                        if (k_q == K_LAST) begin
                            state_d = ST_DONE;
                        end else begin
                            k_d = k_q + K_ONE;
                        end
                    end else if (cnt_q == TO_LAST) begin
                        state_d  = ST_FAULT;
                        cnt_d    = {CNT_W{1'b0}};
                        fstage_d = 4'(k_q);
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                ST_DONE: begin
                    if (stage_ready != ALL_ONES) begin
                        state_d  = ST_FAULT;
                        cnt_d    = {CNT_W{1'b0}};
                        fstage_d = lowest_low(stage_ready);
                    end else begin
                        cnt_d = {CNT_W{1'b0}};
                    end
                end
                ST_FAULT: begin
                    cnt_d = {CNT_W{1'b0}};
                end
                default: begin
                    state_d  = ST_HOLD;
                    cnt_d    = {CNT_W{1'b0}};
                    k_d      = {K_W{1'b0}};
                    fstage_d = 4'd0;
                end
            endcase
        end
    end

    // Output decode from the next state, so that the outputs are registered
    // and change on the same edge as the state.
    always_comb begin
        stage_rst_n_d = {N_STAGES{1'b0}};
        busy_d        = 1'b0;
        done_d        = 1'b0;
        fault_d       = 1'b0;
        case (state_d)
            ST_HOLD: begin
                busy_d = 1'b1;
            end
            ST_WAIT: begin
                busy_d        = 1'b1;
                stage_rst_n_d = therm(k_d);
            end
            ST_DONE: begin
                done_d        = 1'b1;
                stage_rst_n_d = ALL_ONES;
            end
            ST_FAULT: begin
                fault_d = 1'b1;
            end
            default: begin
                busy_d = 1'b1;
            end
        endcase
    end

    // State, counter and output registers. The async clear drops every stage
    // reset immediately, with no clock needed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_HOLD;
            cnt_q         <= {CNT_W{1'b0}};
            k_q           <= {K_W{1'b0}};
            fstage_q      <= 4'd0;
            stage_rst_n_q <= {N_STAGES{1'b0}};
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            k_q           <= k_d;
            fstage_q      <= fstage_d;
            stage_rst_n_q <= stage_rst_n_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            fault_q       <= fault_d;
        end
    end

    assign stage_rst_n = stage_rst_n_q;
    assign seq_busy    = busy_q;
    assign seq_done    = done_q;
    assign fault       = fault_q;
    assign fault_stage = fstage_q;

    rst_sequencer_chk #(
        .N_STAGES (N_STAGES)
    ) u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .stage_rst_n (stage_rst_n_q),
        .seq_busy    (busy_q),
        .seq_done    (done_q),
        .fault       (fault_q)
    );

endmodule

// -----------------------------------------------------------------------------
// rst_sequencer_chk
//   Structural invariants of the sequencer outputs: exactly one status flag is
//   set, the stage resets are thermometer-coded, and no stage is released
//   while a fault is reported.
// Ports
//   clk, rst_n    clock and async reset of the sequencer
//   stage_rst_n   per-stage resets under observation
//   seq_busy, seq_done, fault   status flags under observation
// -----------------------------------------------------------------------------
module rst_sequencer_chk #(
    parameter int N_STAGES = 4
) (
    input logic                clk,
    input logic                rst_n,
    input logic [N_STAGES-1:0] stage_rst_n,
    input logic                seq_busy,
    input logic                seq_done,
    input logic                fault
);

    localparam logic [N_STAGES-1:0] ONE = N_STAGES'(1);

    a_status_onehot: assert property (@(posedge clk) disable iff (!rst_n)
        $onehot({seq_busy, seq_done, fault}));

    a_thermometer: assert property (@(posedge clk) disable iff (!rst_n)
        ((stage_rst_n & (stage_rst_n + ONE)) == {N_STAGES{1'b0}}));

    a_fault_holds_reset: assert property (@(posedge clk) disable iff (!rst_n)
        fault |-> (stage_rst_n == {N_STAGES{1'b0}}));

endmodule

// File: tb/tb_rst_sequencer.sv
// -----------------------------------------------------------------------------
// tb_rst_sequencer
//   Directed bench for rst_sequencer with N_STAGES=3, HOLD_CYC=4,
//   STAGE_DLY=3 and TIMEOUT=10. Inputs are driven and outputs are sampled on
//   the falling clock edge. Cycle c counts rising edges since the sequence
//   started.
// -----------------------------------------------------------------------------
module tb_rst_sequencer;

    localparam int N = 3;

    logic         clk;
    logic         rst_n;
    logic         sw_rst_req;
    logic [N-1:0] stage_ready;
    logic [N-1:0] stage_rst_n;
    logic         seq_busy;
    logic         seq_done;
    logic         fault;
    logic [3:0]   fault_stage;

    int total;
    int bad;

    rst_sequencer #(
        .N_STAGES  (N),
        .CNT_W     (8),
        .HOLD_CYC  (4),
        .STAGE_DLY (3),
        .TIMEOUT   (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sw_rst_req  (sw_rst_req),
        .stage_ready (stage_ready),
        .stage_rst_n (stage_rst_n),
        .seq_busy    (seq_busy),
        .seq_done    (seq_done),
        .fault       (fault),
        .fault_stage (fault_stage)
    );

    // Free-running clock with a 10-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected stage resets in cycle c of a sequence where every stage is ready.
    function automatic logic [31:0] exp_stage(input int c);
        if (c < 4)       return 32'd0;
        else if (c < 7)  return 32'd1;
        else if (c < 10) return 32'd3;
        else             return 32'd7;
    endfunction

    // Step through cycles 1..upto of a sequence with every stage ready, and
    // check all outputs in each cycle.
    task automatic run_seq(input string tag, input int upto);
        for (int c = 1; c <= upto; c++) begin
            @(negedge clk);
            chk($sformatf("%s_c%0d_stage", tag, c), 32'(stage_rst_n), exp_stage(c));
            chk($sformatf("%s_c%0d_busy", tag, c), 32'(seq_busy), (c < 13) ? 32'd1 : 32'd0);
            chk($sformatf("%s_c%0d_done", tag, c), 32'(seq_done), (c >= 13) ? 32'd1 : 32'd0);
            chk($sformatf("%s_c%0d_fault", tag, c), 32'(fault), 32'd0);
        end
    endtask

    // Pulse sw_rst_req for one cycle, then check that the sequencer is back in HOLD.
    task automatic sw_pulse(input string tag);
        sw_rst_req = 1'b1;
        @(negedge clk);
        sw_rst_req = 1'b0;
        chk({tag, "_sw_stage"}, 32'(stage_rst_n), 32'd0);
        chk({tag, "_sw_busy"}, 32'(seq_busy), 32'd1);
        chk({tag, "_sw_fault"}, 32'(fault), 32'd0);
        chk({tag, "_sw_fstage"}, 32'(fault_stage), 32'd0);
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        rst_n       = 1'b0;
        sw_rst_req  = 1'b0;
        stage_ready = 3'b111;

        // Reset values while rst_n is held low.
        repeat (2) @(negedge clk);
        chk("rst_stage", 32'(stage_rst_n), 32'd0);
        chk("rst_busy", 32'(seq_busy), 32'd1);
        chk("rst_done", 32'(seq_done), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_fstage", 32'(fault_stage), 32'd0);

        // Case 1: release rst_n with every stage ready.
        rst_n = 1'b1;
        run_seq("t1", 13);

        // Case 3: drop stage_ready[2] for one cycle while in DONE.
        stage_ready = 3'b011;
        @(negedge clk);
        stage_ready = 3'b111;
        chk("t3_fault", 32'(fault), 32'd1);
        chk("t3_fstage", 32'(fault_stage), 32'd2);
        chk("t3_stage", 32'(stage_rst_n), 32'd0);
        chk("t3_done", 32'(seq_done), 32'd0);
        chk("t3_busy", 32'(seq_busy), 32'd0);
        @(negedge clk);
        chk("t3_fault_held", 32'(fault), 32'd1);

        // Case 5: sw_rst_req in FAULT, then a normal sequence.
        sw_pulse("t5");
        run_seq("t5", 13);

        // Case 2: stage_ready[1] held low. The sw request comes in the same
        // cycle as a ready drop in DONE, so it also checks that sw wins.
        stage_ready = 3'b101;
        sw_pulse("t2");
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            if (c < 17) begin
                chk($sformatf("t2_c%0d_stage", c), 32'(stage_rst_n),
                    (c < 4) ? 32'd0 : ((c < 7) ? 32'd1 : 32'd3));
                chk($sformatf("t2_c%0d_fault", c), 32'(fault), 32'd0);
            end else begin
                chk("t2_to_stage", 32'(stage_rst_n), 32'd0);
                chk("t2_to_fault", 32'(fault), 32'd1);
                chk("t2_to_fstage", 32'(fault_stage), 32'd1);
                chk("t2_to_busy", 32'(seq_busy), 32'd0);
            end
        end

        // Case 4: sw_rst_req while stage_rst_n=011. The request comes on the
        // edge where stage 2 would otherwise be released.
        stage_ready = 3'b111;
        sw_pulse("t4a");
        run_seq("t4a", 9);
        sw_pulse("t4b");
        run_seq("t4b", 13);

        // Case 6: async reset in WAIT, with no clock edge in between.
        sw_pulse("t6");
        run_seq("t6a", 5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_stage", 32'(stage_rst_n), 32'd0);
        chk("t6_async_busy", 32'(seq_busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        run_seq("t6b", 13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
